// File: rtl/bus_pkg.sv
// Shared constants and types for the 6502 memory/IO bus.
// Region map, IO page offsets and UART transmitter states.
package bus_pkg;

  localparam logic [15:0] RAM_BASE  = 16'h0000;
  localparam logic [15:0] RAM_LIMIT = 16'h7FFF;
  localparam logic [15:0] IO_BASE   = 16'hD000;
  localparam logic [15:0] IO_LIMIT  = 16'hD00F;
  localparam logic [15:0] ROM_BASE  = 16'hE000;
  localparam logic [15:0] ROM_LIMIT = 16'hFFFF;

  localparam logic [3:0] IO_LED       = 4'h0;
  localparam logic [3:0] IO_SW        = 4'h1;
  localparam logic [3:0] IO_UART_DATA = 4'h2;
  localparam logic [3:0] IO_UART_STAT = 4'h3;
  localparam logic [3:0] IO_CNT_LO    = 4'h4;
  localparam logic [3:0] IO_CNT_HI    = 4'h5;

  localparam logic [7:0] UNMAPPED = 8'hFF;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  function automatic logic in_range(
    input logic [15:0] a,
    input logic [15:0] lo,
    input logic [15:0] hi
  );
    return (a >= lo) && (a <= hi);
  endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 serial transmitter, LSB first, idle high.
// One frame is 10 bit periods of CLKS_PER_BIT clocks each.
module uart_tx
  import bus_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t state, state_n;
  logic [CW-1:0] baud, baud_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shreg, shreg_n;
  logic bit_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= UART_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
    end
  end

  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx        = 1'b1;
    bit_end   = (baud == LAST);
    unique case (state)
      UART_IDLE: begin
        if (start) begin
          state_n = UART_START;
          baud_n  = '0;
          shreg_n = data;
        end
      end
      UART_START: begin
        tx = 1'b0;
        if (bit_end) begin
          state_n   = UART_DATA;
          baud_n    = '0;
          bit_idx_n = '0;
        end else begin
          baud_n = baud + CW'(1);
        end
      end
      UART_DATA: begin
        tx = shreg[0];
        if (bit_end) begin
          baud_n  = '0;
          shreg_n = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = UART_STOP;
          else bit_idx_n = bit_idx + 3'd1;
        end else begin
          baud_n = baud + CW'(1);
        end
      end
      UART_STOP: begin
        if (bit_end) begin
          state_n = UART_IDLE;
          baud_n  = '0;
        end else begin
          baud_n = baud + CW'(1);
        end
      end
      default: state_n = UART_IDLE;
    endcase
  end

  assign busy = (state != UART_IDLE);

endmodule

// File: rtl/memory_io_bus.sv
// Address decode, mirrored RAM, ROM port and IO page for the 6502 bus.
// Reads are combinational; all writes land on the rising edge.
module memory_io_bus
  import bus_pkg::*;
#(
  parameter int RAM_ADDR_BITS = 11,
  parameter int CLKS_PER_BIT  = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] address,
  input  logic        read_write,
  input  logic [7:0]  data_write,
  output logic [7:0]  data_read,
  output logic [12:0] rom_address,
  input  logic [7:0]  rom_data,
  input  logic [7:0]  switches,
  output logic [7:0]  leds,
  output logic        uart_tx
);

  logic [7:0] ram [2**RAM_ADDR_BITS];
  logic [RAM_ADDR_BITS-1:0] ram_idx;

  logic [7:0]  sw_meta, sw_sync;
  logic [7:0]  cnt_hi_shadow;
  logic [15:0] counter;
  logic        overrun, busy;
  logic        in_ram, in_io, in_rom;
  logic        wr, rd;
  logic [3:0]  off;
  logic [7:0]  io_rdata;
  logic        led_wr, data_wr, stat_wr, lo_rd;
  logic        tx_start;

  assign rom_address = address[12:0];
  assign ram_idx     = address[RAM_ADDR_BITS-1:0];
  assign off         = address[3:0];

  assign in_ram = in_range(address, RAM_BASE, RAM_LIMIT);
  assign in_io  = in_range(address, IO_BASE, IO_LIMIT);
  assign in_rom = in_range(address, ROM_BASE, ROM_LIMIT);

  assign wr = ~read_write;
  assign rd = read_write;

  assign led_wr   = wr && in_io && (off == IO_LED);
  assign data_wr  = wr && in_io && (off == IO_UART_DATA);
  assign stat_wr  = wr && in_io && (off == IO_UART_STAT);
  assign lo_rd    = rd && in_io && (off == IO_CNT_LO);
  assign tx_start = data_wr && !busy;

  always_ff @(posedge clk) begin
    if (wr && in_ram && !rst) ram[ram_idx] <= data_write;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leds          <= '0;
      overrun       <= 1'b0;
      counter       <= '0;
      cnt_hi_shadow <= '0;
      sw_meta       <= '0;
      sw_sync       <= '0;
    end else begin
      counter <= counter + 16'd1;
      sw_meta <= switches;
      sw_sync <= sw_meta;
      if (led_wr) leds <= data_write;
      // a dropped byte and a status clear cannot share one bus cycle
      if (data_wr && busy) overrun <= 1'b1;
      else if (stat_wr) overrun <= 1'b0;
      // pre-increment high byte pairs with the low byte returned now
      if (lo_rd) cnt_hi_shadow <= counter[15:8];
    end
  end

  always_comb begin
    io_rdata = 8'h00;
    unique case (off)
      IO_LED:       io_rdata = leds;
      IO_SW:        io_rdata = sw_sync;
      IO_UART_STAT: io_rdata = {6'b0, overrun, busy};
      IO_CNT_LO:    io_rdata = counter[7:0];
      IO_CNT_HI:    io_rdata = cnt_hi_shadow;
      default:      io_rdata = 8'h00;
    endcase
  end

  always_comb begin
    data_read = UNMAPPED;
    unique case (1'b1)
      in_ram:  data_read = ram[ram_idx];
      in_io:   data_read = io_rdata;
      in_rom:  data_read = rom_data;
      default: data_read = UNMAPPED;
    endcase
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst  (rst),
    .start(tx_start),
    .data (data_write),
    .tx   (uart_tx),
    .busy (busy)
  );

endmodule

// File: tb/tb_memory_io_bus.sv
// Scoreboard bench for memory_io_bus: bus reads and serial frames
// are checked against a cycle-counting reference model.
module tb_memory_io_bus;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] address = 16'h8000;
  logic        read_write = 1'b1;
  logic [7:0]  data_write = 8'h00;
  logic [7:0]  data_read;
  logic [12:0] rom_address;
  logic [7:0]  rom_data = 8'h00;
  logic [7:0]  switches = 8'h00;
  logic [7:0]  leds;
  logic        uart_tx;

  memory_io_bus #(
    .RAM_ADDR_BITS(11),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .address    (address),
    .read_write (read_write),
    .data_write (data_write),
    .data_read  (data_read),
    .rom_address(rom_address),
    .rom_data   (rom_data),
    .switches   (switches),
    .leds       (leds),
    .uart_tx    (uart_tx)
  );

  always #5 clk = ~clk;

  // cycles since reset: equals the free-running counter
  int cyc = 0;
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  int nerr = 0;
  int nchk = 0;

  string      nq[$];
  logic [7:0] eq[$];
  logic [12:0] rq[$];
  logic [7:0] rxq[$];

  logic [7:0] ram_m [2048];
  bit         ram_v [2048];
  logic [7:0] leds_m = 8'h00;
  logic [7:0] shadow_m = 8'h00;
  bit         ovr_m = 1'b0;
  int         tx_end = -1000;
  logic [7:0] sw_prev = 8'h00;
  logic [7:0] sw_now = 8'h00;
  int         sw_chg = 0;
  logic [7:0] rom_next = 8'h00;

  task automatic check(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit m_busy();
    return cyc <= tx_end;
  endfunction

  function automatic logic [7:0] m_sw();
    return (cyc >= sw_chg + 2) ? sw_now : sw_prev;
  endfunction

  function automatic void mread(input logic [15:0] a,
                                output logic [7:0] e, output bit ok);
    ok = 1'b1;
    e  = 8'hFF;
    if (a <= 16'h7FFF) begin
      e  = ram_m[a[10:0]];
      ok = ram_v[a[10:0]];
    end else if (a >= 16'hD000 && a <= 16'hD00F) begin
      case (a[3:0])
        4'h0:    e = leds_m;
        4'h1:    e = m_sw();
        4'h3:    e = {6'b0, ovr_m, m_busy()};
        4'h4:    e = 8'(cyc);
        4'h5:    e = shadow_m;
        default: e = 8'h00;
      endcase
    end else if (a >= 16'hE000) begin
      e = rom_next;
    end
  endfunction

  task automatic op(input logic [15:0] a, input bit rd,
                    input logic [7:0] wd, input bit chk, input string nm);
    logic [7:0] e;
    bit ok;
    address    = a;
    read_write = rd;
    data_write = wd;
    rom_data   = rom_next;
    if (rd && chk) begin
      mread(a, e, ok);
      if (ok) begin
        nq.push_back(nm);
        eq.push_back(e);
        rq.push_back(a[12:0]);
      end
    end
    if (rd && a == 16'hD004) shadow_m = 8'(cyc >> 8);
    if (!rd) begin
      if (a <= 16'h7FFF) begin
        ram_m[a[10:0]] = wd;
        ram_v[a[10:0]] = 1'b1;
      end else if (a >= 16'hD000 && a <= 16'hD00F) begin
        case (a[3:0])
          4'h0: leds_m = wd;
          4'h2: begin
            if (m_busy()) ovr_m = 1'b1;
            else begin
              tx_end = cyc + FRAME;
              rxq.push_back(wd);
            end
          end
          4'h3: ovr_m = 1'b0;
          default: ;
        endcase
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op(16'h8000, 1'b1, 8'h00, 1'b0, "idle");
  endtask

  task automatic set_sw(input logic [7:0] v);
    sw_prev  = m_sw();
    sw_now   = v;
    sw_chg   = cyc;
    switches = v;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    read_write = 1'b1;
    address    = 16'h8000;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    leds_m   = 8'h00;
    shadow_m = 8'h00;
    ovr_m    = 1'b0;
    tx_end   = -1000;
    sw_prev  = 8'h00;
    sw_now   = switches;
    sw_chg   = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3 * FRAME && m_busy(); i++) idle();
  endtask

  // read monitor: one scoreboard entry per checked read
  initial begin
    string nm;
    forever begin
      @(negedge clk);
      if (nq.size() != 0) begin
        nm = nq.pop_front();
        check(nm, 16'(data_read), 16'(eq.pop_front()));
        check({nm, "_romaddr"}, 16'(rom_address), 16'(rq.pop_front()));
      end
    end
  end

  // serial monitor: decodes frames and checks each bit is held CPB clocks
  initial begin
    logic [9:0] bits;
    int bad;
    bit abort;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        bits  = '0;
        bad   = 0;
        abort = 1'b0;
        for (int k = 0; k < FRAME; k++) begin
          if (k != 0) @(negedge clk);
          if (rst) begin
            abort = 1'b1;
            break;
          end
          if (k % CPB == 0) bits[k/CPB] = uart_tx;
          else if (uart_tx !== bits[k/CPB]) bad++;
        end
        if (abort) begin
          if (rxq.size() != 0) void'(rxq.pop_front());
        end else begin
          check("rx_shape", 16'(bad), 16'd0);
          check("rx_framing", 16'({bits[9], bits[0]}), 16'd2);
          if (rxq.size() == 0) check("rx_unexpected", 16'd1, 16'd0);
          else check("rx_byte", 16'(bits[8:1]), 16'(rxq.pop_front()));
        end
      end
    end
  end

  initial begin
    int t;
    int cls;
    logic [15:0] a;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    check("rst_tx", 16'(uart_tx), 16'd1);
    check("rst_leds", 16'(leds), 16'd0);
    op(16'hD000, 1'b1, 8'h00, 1'b1, "rst_led");
    op(16'hD003, 1'b1, 8'h00, 1'b1, "rst_stat");
    op(16'hD005, 1'b1, 8'h00, 1'b1, "rst_cnthi");
    op(16'hD001, 1'b1, 8'h00, 1'b1, "rst_sw");
    op(16'hD004, 1'b1, 8'h00, 1'b1, "cnt_early");

    while (cyc < 16'h12FF) idle();
    op(16'hD004, 1'b1, 8'h00, 1'b1, "cnt_lo_wrap");
    repeat (4) idle();
    op(16'hD005, 1'b1, 8'h00, 1'b1, "cnt_hi_shadow");

    op(16'h0124, 1'b0, 8'h33, 1'b1, "w");
    op(16'h0123, 1'b0, 8'h5A, 1'b1, "w");
    op(16'h0123, 1'b1, 8'h00, 1'b1, "ram_rd");
    op(16'h0923, 1'b1, 8'h00, 1'b1, "ram_mirror");
    op(16'h0124, 1'b1, 8'h00, 1'b1, "ram_neighbour");

    rom_next = 8'hEA;
    op(16'hFFFC, 1'b1, 8'h00, 1'b1, "rom_rd");
    op(16'h9000, 1'b1, 8'h00, 1'b1, "unmapped");
    op(16'hE000, 1'b0, 8'h99, 1'b1, "w");
    op(16'h0123, 1'b1, 8'h00, 1'b1, "rom_wr_ram");
    op(16'hD000, 1'b1, 8'h00, 1'b1, "rom_wr_led");

    op(16'hD000, 1'b0, 8'hC7, 1'b1, "w");
    check("leds_port", 16'(leds), 16'(leds_m));
    op(16'hD000, 1'b1, 8'h00, 1'b1, "led_rd");
    set_sw(8'hA6);
    op(16'hD001, 1'b1, 8'h00, 1'b1, "sw_t0");
    op(16'hD001, 1'b1, 8'h00, 1'b1, "sw_t1");
    op(16'hD001, 1'b1, 8'h00, 1'b1, "sw_t2");
    op(16'hD001, 1'b0, 8'h00, 1'b1, "w");
    op(16'hD001, 1'b1, 8'h00, 1'b1, "sw_wr_ignored");

    t = cyc;
    op(16'hD002, 1'b0, 8'hA5, 1'b1, "w");
    op(16'hD003, 1'b1, 8'h00, 1'b1, "stat_busy");
    op(16'hD002, 1'b1, 8'h00, 1'b1, "uart_data_rd");
    while (cyc < t + FRAME) idle();
    op(16'hD003, 1'b1, 8'h00, 1'b1, "stat_last_busy");
    op(16'hD003, 1'b1, 8'h00, 1'b1, "stat_done");

    t = cyc;
    op(16'hD002, 1'b0, 8'h3C, 1'b1, "w");
    while (cyc < t + FRAME) idle();
    op(16'hD002, 1'b0, 8'h77, 1'b1, "w");
    op(16'hD002, 1'b0, 8'h96, 1'b1, "w");
    op(16'hD003, 1'b1, 8'h00, 1'b1, "stat_stop_ovr");
    op(16'hD003, 1'b0, 8'h00, 1'b1, "w");
    op(16'hD003, 1'b1, 8'h00, 1'b1, "stat_clr");
    wait_idle();

    op(16'hD002, 1'b0, 8'h11, 1'b1, "w");
    idle();
    op(16'hD002, 1'b0, 8'h22, 1'b1, "w");
    op(16'hD003, 1'b1, 8'h00, 1'b1, "ovr_stat");
    op(16'hD003, 1'b0, 8'h00, 1'b1, "w");
    op(16'hD003, 1'b1, 8'h00, 1'b1, "ovr_clr");
    wait_idle();

    op(16'hD000, 1'b0, 8'h5F, 1'b1, "w");
    t = cyc;
    op(16'hD002, 1'b0, 8'h5C, 1'b1, "w");
    while (cyc < t + 10) idle();
    do_reset();
    check("rst_mid_tx", 16'(uart_tx), 16'd1);
    check("rst_mid_leds", 16'(leds), 16'd0);
    op(16'hD003, 1'b1, 8'h00, 1'b1, "rst_mid_stat");
    op(16'hD002, 1'b0, 8'hC3, 1'b1, "w");
    wait_idle();

    for (int i = 0; i < 400; i++) begin
      rom_next = 8'($urandom);
      if ($urandom_range(0, 15) == 0 && cyc >= sw_chg + 2)
        set_sw(8'($urandom));
      cls = $urandom_range(0, 3);
      case (cls)
        0: a = {1'b0, 4'($urandom), 11'h100 + 11'($urandom_range(0, 15))};
        1: a = 16'hD000 + 16'($urandom_range(0, 15));
        2: a = 16'hE000 + 16'($urandom_range(0, 8191));
        default: begin
          if ($urandom_range(0, 1) == 0)
            a = 16'h8000 + 16'($urandom_range(0, 16'h4FFF));
          else
            a = 16'hD010 + 16'($urandom_range(0, 16'h0FEF));
        end
      endcase
      op(a, 1'($urandom_range(0, 1)), 8'($urandom), 1'b1, "rnd");
    end

    wait_idle();
    repeat (5) idle();
    check("rx_drain", 16'(rxq.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
